// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-source round-robin select path: source
// encodings, default widths and the output-stage state type.
package mux2_rr_arbiter_pkg;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  localparam int N_DEF    = 12;
  localparam int CNTW_DEF = 8;

  // The output register is either holding a word or not; FULL mirrors f_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the two requester handshakes, the consumer handshake and the
// status/debug outputs of mux2_rr_arbiter.
interface mux2_rr_arbiter_if
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int CNTW = CNTW_DEF
);

  // Handshake rule for every channel here: a word moves on a rising clk edge
  // exactly when valid and ready are both high; the producer holds valid and
  // data stable until that edge, and ready may depend combinationally on the
  // consumer's ready in the same cycle.
  logic            a_valid;
  logic [N-1:0]    a_data;
  logic            a_ready;
  logic            b_valid;
  logic [N-1:0]    b_data;
  logic            b_ready;
  logic            f_valid;
  logic [N-1:0]    f_data;
  logic            f_ready;
  logic            s_out;
  logic [CNTW-1:0] cnt_a;
  logic [CNTW-1:0] cnt_b;
  state_t          dbg_state;
  logic            dbg_pri;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, f_ready,
    output a_ready, b_ready, f_valid, f_data, s_out, cnt_a, cnt_b,
           dbg_state, dbg_pri
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, f_ready,
    input  a_ready, b_ready, f_valid, f_data, s_out, cnt_a, cnt_b,
           dbg_state, dbg_pri
  );

endinterface

// File: rtl/mux2_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational; the caller owns the
// priority pointer and decides when grants are allowed through en.
module rr_arb2
  import mux2_rr_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic pri,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b,
  output logic any
);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      // A tie is the only case where the pointer matters.
      if (req_a && req_b) begin
        gnt_a = (pri == SRC_A);
        gnt_b = (pri == SRC_B);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    any = gnt_a | gnt_b;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin share of one N-bit 2:1 select between requesters A and B,
// captured in a single valid/ready output register with per-source counters.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int CNTW = CNTW_DEF
)(
  input  logic               clk,
  input  logic               rst,
  mux2_rr_arbiter_if.slave   bus
);

  state_t          state_q, state_d;
  logic            pri_q;
  logic [N-1:0]    f_data_q;
  logic            s_q;
  logic [CNTW-1:0] cnt_a_q;
  logic [CNTW-1:0] cnt_b_q;

  logic            load_en;
  logic            gnt_a;
  logic            gnt_b;
  logic            any;
  logic            sel;
  logic [N-1:0]    mux_out;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // The register can take a word when it is empty or its word leaves now.
  assign load_en = (state_q == EMPTY) | bus.f_ready;

  // Reset also blocks grants so no requester sees ready while rst is high.
  rr_arb2 u_arb (
    .req_a (bus.a_valid),
    .req_b (bus.b_valid),
    .pri   (pri_q),
    .en    (load_en & ~rst),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .any   (any)
  );

  assign sel     = gnt_a ? SRC_A : SRC_B;
  assign mux_out = (sel == SRC_A) ? bus.a_data : bus.b_data;

  always_comb begin
    state_d = state_q;
    if (load_en) begin
      state_d = any ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data and source only change on a grant; a drain keeps the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_data_q <= '0;
      s_q      <= 1'b0;
      pri_q    <= SRC_A;
    end else if (any) begin
      f_data_q <= mux_out;
      s_q      <= sel;
      pri_q    <= ~sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (gnt_a && (cnt_a_q != CNT_MAX)) begin
        cnt_a_q <= cnt_a_q + 1'b1;
      end
      if (gnt_b && (cnt_b_q != CNT_MAX)) begin
        cnt_b_q <= cnt_b_q + 1'b1;
      end
    end
  end

  assign bus.a_ready   = gnt_a;
  assign bus.b_ready   = gnt_b;
  assign bus.f_valid   = (state_q == FULL);
  assign bus.f_data    = f_data_q;
  assign bus.s_out     = s_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_pri   = pri_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: expected output words go into a queue
// as they are granted and a negedge monitor pops them on each output transfer.
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;

  localparam int W = 12;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  // {s_out, f_data} of each word expected at the output, oldest first
  logic [W:0] exp_q[$];

  mux2_rr_arbiter_if #(.N(W), .CNTW(8)) bus ();
  mux2_rr_arbiter_if #(.N(W), .CNTW(2)) sbus ();

  mux2_rr_arbiter #(.N(W), .CNTW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux2_rr_arbiter #(.N(W), .CNTW(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_exp(input logic s, input logic [W-1:0] d);
    exp_q.push_back({s, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.f_valid && bus.f_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(bus.f_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.f_data), 32'(e[W-1:0]));
          check("out_src", 32'(bus.s_out), 32'(e[W]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] ab_data[2];
  logic [1:0]   sat_exp[5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ab_data[0]   = 12'hAAA;
    ab_data[1]   = 12'h555;
    sat_exp[0]   = 2'd1;
    sat_exp[1]   = 2'd2;
    sat_exp[2]   = 2'd3;
    sat_exp[3]   = 2'd3;
    sat_exp[4]   = 2'd3;

    rst          = 1'b1;
    bus.a_valid  = 1'b1;
    bus.a_data   = 12'h7FF;
    bus.b_valid  = 1'b1;
    bus.b_data   = 12'h001;
    bus.f_ready  = 1'b1;
    sbus.a_valid = 1'b0;
    sbus.a_data  = '0;
    sbus.b_valid = 1'b0;
    sbus.b_data  = '0;
    sbus.f_ready = 1'b1;

    // Reset values, and no ready while rst is high even with requests pending
    step();
    check("rst_a_ready", 32'(bus.a_ready), 0);
    check("rst_b_ready", 32'(bus.b_ready), 0);
    check("rst_f_valid", 32'(bus.f_valid), 0);
    check("rst_f_data", 32'(bus.f_data), 0);
    check("rst_s_out", 32'(bus.s_out), 0);
    check("rst_cnt_a", 32'(bus.cnt_a), 0);
    check("rst_cnt_b", 32'(bus.cnt_b), 0);
    check("rst_pri", 32'(bus.dbg_pri), 32'(SRC_A));
    check("rst_state", 32'(bus.dbg_state), 32'(EMPTY));
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b0;
    step();

    // Solo A
    bus.a_valid = 1'b1;
    bus.a_data  = 12'h123;
    settle();
    check("solo_a_ready", 32'(bus.a_ready), 1);
    check("solo_b_ready", 32'(bus.b_ready), 0);
    push_exp(1'b1, 12'h123);
    step();
    bus.a_valid = 1'b0;
    check("solo_f_valid", 32'(bus.f_valid), 1);
    check("solo_f_data", 32'(bus.f_data), 32'h123);
    check("solo_s_out", 32'(bus.s_out), 1);
    check("solo_cnt_a", 32'(bus.cnt_a), 1);
    check("solo_pri", 32'(bus.dbg_pri), 32'(SRC_B));

    // A lone A flipped the pointer, so this tie goes to B, then A follows
    bus.a_valid = 1'b1;
    bus.a_data  = 12'h0AB;
    bus.b_valid = 1'b1;
    bus.b_data  = 12'h0CD;
    settle();
    check("tie_b_ready", 32'(bus.b_ready), 1);
    check("tie_a_ready", 32'(bus.a_ready), 0);
    push_exp(1'b0, 12'h0CD);
    step();
    bus.b_valid = 1'b0;
    settle();
    check("tie_a_next", 32'(bus.a_ready), 1);
    push_exp(1'b1, 12'h0AB);
    step();
    bus.a_valid = 1'b0;
    check("tie_cnt_a", 32'(bus.cnt_a), 2);
    check("tie_cnt_b", 32'(bus.cnt_b), 1);

    // Contention from reset: A,B,A,B with no bubbles
    do_reset();
    bus.f_ready = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_data  = ab_data[0];
    bus.b_valid = 1'b1;
    bus.b_data  = ab_data[1];
    for (int i = 0; i < 4; i++) begin
      settle();
      check("cont_a_ready", 32'(bus.a_ready), 32'((i % 2) == 0));
      check("cont_b_ready", 32'(bus.b_ready), 32'((i % 2) == 1));
      push_exp((i % 2) == 0, ab_data[i % 2]);
      step();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check("cont_cnt_a", 32'(bus.cnt_a), 2);
    check("cont_cnt_b", 32'(bus.cnt_b), 2);
    check("cont_last", 32'(bus.f_data), 32'h555);
    step();

    // Reset mid-transfer: held word discarded asynchronously
    bus.f_ready = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data  = 12'h5A5;
    step();
    bus.a_valid = 1'b0;
    check("mid_f_valid", 32'(bus.f_valid), 1);
    check("mid_f_data", 32'(bus.f_data), 32'h5A5);
    check("mid_cnt_a", 32'(bus.cnt_a), 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_f_valid", 32'(bus.f_valid), 0);
    check("arst_f_data", 32'(bus.f_data), 0);
    check("arst_s_out", 32'(bus.s_out), 0);
    check("arst_cnt_a", 32'(bus.cnt_a), 0);
    check("arst_pri", 32'(bus.dbg_pri), 32'(SRC_A));
    exp_q.delete();
    step();
    rst = 1'b0;

    // Back-pressure: FULL with 0x0F0, consumer stalls for 3 cycles
    bus.b_valid = 1'b1;
    bus.b_data  = 12'h0F0;
    settle();
    check("bp_load_b", 32'(bus.b_ready), 1);
    push_exp(1'b0, 12'h0F0);
    step();
    bus.a_valid = 1'b1;
    bus.a_data  = 12'h111;
    bus.b_data  = 12'h222;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_a_ready", 32'(bus.a_ready), 0);
      check("bp_b_ready", 32'(bus.b_ready), 0);
      step();
      check("bp_hold", 32'(bus.f_data), 32'h0F0);
      check("bp_valid", 32'(bus.f_valid), 1);
    end
    bus.f_ready = 1'b1;
    settle();
    check("bp_release_a", 32'(bus.a_ready), 1);
    check("bp_release_b", 32'(bus.b_ready), 0);
    push_exp(1'b1, 12'h111);
    step();
    bus.a_valid = 1'b0;
    settle();
    check("bp_then_b", 32'(bus.b_ready), 1);
    push_exp(1'b0, 12'h222);
    step();
    bus.b_valid = 1'b0;
    check("bp_cnt_a", 32'(bus.cnt_a), 1);
    check("bp_cnt_b", 32'(bus.cnt_b), 2);

    // Drain to empty after an A word: data and source are kept
    bus.a_valid = 1'b1;
    bus.a_data  = 12'h3C3;
    push_exp(1'b1, 12'h3C3);
    step();
    bus.a_valid = 1'b0;
    step();
    check("drain_f_valid", 32'(bus.f_valid), 0);
    check("drain_f_data", 32'(bus.f_data), 32'h3C3);
    check("drain_s_out", 32'(bus.s_out), 1);
    check("drain_state", 32'(bus.dbg_state), 32'(EMPTY));
    check("sb_empty", 32'(exp_q.size()), 0);

    // Saturation on the CNTW=2 instance
    sbus.a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sbus.a_data = W'(i + 1);
      step();
      check("sat_cnt_a", 32'(sbus.cnt_a), 32'(sat_exp[i]));
      check("sat_cnt_b", 32'(sbus.cnt_b), 0);
      check("sat_f_data", 32'(sbus.f_data), 32'(i + 1));
    end
    sbus.a_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
